// File: rtl/ac_motor_pwm_sequencer.sv
// ac_motor_pwm_sequencer
// Three-phase inverter gate sequencer built around an external triangle carrier.
// Runs IDLE/CHARGE/RUN/FAULT, accepts double-buffered phase references via a
// valid/ready handshake (applied on the carrier-peak SYNC pulse), compares them
// against the carrier and drives six dead-time-protected gate outputs.
//
// Optional build macro: AC_MOTOR_SEQ_FAULT_FILTER_EN
//   defined   -> FAULT must stay high FAULT_FILTER consecutive cycles to trip
//   undefined -> a single FAULT-high cycle trips (FAULT_FILTER unused)
module ac_motor_pwm_sequencer #(
   parameter int OUTPUT_BITS    = 24,
   parameter int DEAD_CYCLES    = 50,
   parameter int DEAD_BITS      = 8,
   parameter int CHARGE_PERIODS = 4,
   parameter int FAULT_FILTER   = 4
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic signed [OUTPUT_BITS-1:0] TRIANGLE,
   input  logic                          SYNC,
   input  logic                          START,
   input  logic                          STOP,
   input  logic                          FAULT,
   input  logic                          CLEAR,
   input  logic signed [OUTPUT_BITS-1:0] REF_A,
   input  logic signed [OUTPUT_BITS-1:0] REF_B,
   input  logic signed [OUTPUT_BITS-1:0] REF_C,
   input  logic                          REF_VALID,
   output logic                          REF_READY,
   output logic [2:0]                    GATE_HI,
   output logic [2:0]                    GATE_LO,
   output logic [1:0]                    STATE,
   output logic                          FAULT_LATCHED
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHARGE = 2'd1,
      ST_RUN    = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   // Charge counter only needs to hold 0 .. CHARGE_PERIODS-1.
   localparam int CHG_W = (CHARGE_PERIODS > 1) ? $clog2(CHARGE_PERIODS) : 1;
   localparam logic [CHG_W-1:0]     CHG_LAST  = CHG_W'(CHARGE_PERIODS - 1);
   localparam logic [DEAD_BITS-1:0] DEAD_LOAD = DEAD_BITS'(DEAD_CYCLES);
   localparam logic [DEAD_BITS-1:0] DEAD_ONE  = DEAD_BITS'(1);

   // ---------------------------------------------------------------------
   // Sequencer control state
   // ---------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [CHG_W-1:0] charge_cnt_q, charge_cnt_d;
   logic             stop_pend_q, stop_pend_d;
   logic             trip;

   // ---------------------------------------------------------------------
   // Reference double buffer
   // ---------------------------------------------------------------------
   logic signed [OUTPUT_BITS-1:0] ref_in    [3];
   logic signed [OUTPUT_BITS-1:0] shadow_q  [3];
   logic signed [OUTPUT_BITS-1:0] shadow_d  [3];
   logic signed [OUTPUT_BITS-1:0] active_q  [3];
   logic signed [OUTPUT_BITS-1:0] active_d  [3];
   logic                          pending_q, pending_d;
   logic                          xfer;
   logic                          stay_active;

   // ---------------------------------------------------------------------
   // Per-phase comparator and dead-time generator
   // ---------------------------------------------------------------------
   logic [2:0]           desired_q, desired_d;
   logic [2:0]           dlast_q, dlast_d;
   logic [DEAD_BITS-1:0] dead_cnt_q [3];
   logic [DEAD_BITS-1:0] dead_cnt_d [3];
   logic [2:0]           gate_hi_q, gate_hi_d;
   logic [2:0]           gate_lo_q, gate_lo_d;

`ifdef AC_MOTOR_SEQ_FAULT_FILTER_EN
   localparam int FLT_W = $clog2(FAULT_FILTER + 1);
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FAULT_FILTER - 1);
   logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;

   // Count consecutive FAULT-high cycles; trip on the FAULT_FILTER-th one.
   always_comb begin
      flt_cnt_d = '0;
      trip      = 1'b0;
      if (FAULT) begin
         trip      = (flt_cnt_q == FLT_LAST);
         flt_cnt_d = (flt_cnt_q == FLT_LAST) ? flt_cnt_q : flt_cnt_q + FLT_W'(1);
      end
   end

   // Fault filter counter register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) flt_cnt_q <= '0;
      else        flt_cnt_q <= flt_cnt_d;
   end
`else
   // Unfiltered: any FAULT-high cycle trips.
   always_comb begin
      trip = FAULT;
   end
`endif

   // Next-state logic: trip has absolute priority, STOP beats START.
   always_comb begin
      state_d      = state_q;
      charge_cnt_d = '0;
      stop_pend_d  = 1'b0;
      if (trip) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (START && !STOP && !FAULT) state_d = ST_CHARGE;
            end
            ST_CHARGE: begin
               if (STOP) begin
                  state_d = ST_IDLE;
               end else if (SYNC) begin
                  if (charge_cnt_q == CHG_LAST) state_d = ST_RUN;
                  else                          charge_cnt_d = charge_cnt_q + CHG_W'(1);
               end else begin
                  charge_cnt_d = charge_cnt_q;
               end
            end
            ST_RUN: begin
               // A stop request is remembered and honoured at the carrier peak
               // so the last PWM period completes symmetrically.
               if (SYNC && (stop_pend_q || STOP)) state_d = ST_IDLE;
               else                               stop_pend_d = stop_pend_q | STOP;
            end
            ST_FAULT: begin
               if (CLEAR && !FAULT) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Sequencer state registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         charge_cnt_q <= '0;
         stop_pend_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         charge_cnt_q <= charge_cnt_d;
         stop_pend_q  <= stop_pend_d;
      end
   end

   assign REF_READY     = ((state_q == ST_CHARGE) || (state_q == ST_RUN)) && !pending_q;
   assign xfer          = REF_VALID && REF_READY;
   assign stay_active   = (state_d == ST_CHARGE) || (state_d == ST_RUN);
   assign STATE         = state_q;
   assign FAULT_LATCHED = (state_q == ST_FAULT);

   // Shadow captures on handshake; active updates only at SYNC. A transfer on
   // the SYNC cycle cannot coincide with an apply because READY is !pending.
   always_comb begin
      ref_in[0] = REF_A;
      ref_in[1] = REF_B;
      ref_in[2] = REF_C;
      pending_d = pending_q;
      for (int x = 0; x < 3; x++) begin
         shadow_d[x] = xfer ? ref_in[x] : shadow_q[x];
         active_d[x] = active_q[x];
      end
      if (!stay_active) begin
         pending_d = 1'b0;
      end else if (xfer) begin
         pending_d = 1'b1;
      end else if (SYNC && pending_q) begin
         pending_d = 1'b0;
         for (int x = 0; x < 3; x++) active_d[x] = shadow_q[x];
      end
   end

   // Reference buffer registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pending_q <= 1'b0;
         for (int x = 0; x < 3; x++) begin
            shadow_q[x] <= '0;
            active_q[x] <= '0;
         end
      end else begin
         pending_q <= pending_d;
         for (int x = 0; x < 3; x++) begin
            shadow_q[x] <= shadow_d[x];
            active_q[x] <= active_d[x];
         end
      end
   end

   // Comparator plus dead-time: gates follow the state being entered so
   // IDLE/FAULT blank the outputs on the same edge that enters them. CHARGE
   // leaves every phase parked low-side-on, which is the starting point of
   // the dead-time tracking when RUN begins.
   always_comb begin
      for (int x = 0; x < 3; x++) begin
         desired_d[x]  = (active_q[x] > TRIANGLE);
         dlast_d[x]    = 1'b0;
         dead_cnt_d[x] = '0;
         gate_hi_d[x]  = 1'b0;
         gate_lo_d[x]  = 1'b0;
         case (state_d)
            ST_CHARGE: begin
               gate_lo_d[x] = 1'b1;
            end
            ST_RUN: begin
               if (desired_q[x] != dlast_q[x]) begin
                  dlast_d[x]    = desired_q[x];
                  dead_cnt_d[x] = DEAD_LOAD;
               end else begin
                  dlast_d[x] = dlast_q[x];
                  if (dead_cnt_q[x] > DEAD_ONE) begin
                     dead_cnt_d[x] = dead_cnt_q[x] - DEAD_ONE;
                  end else begin
                     gate_hi_d[x] = dlast_q[x];
                     gate_lo_d[x] = !dlast_q[x];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Comparator, dead-time and gate output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         desired_q <= '0;
         dlast_q   <= '0;
         gate_hi_q <= '0;
         gate_lo_q <= '0;
         for (int x = 0; x < 3; x++) dead_cnt_q[x] <= '0;
      end else begin
         desired_q <= desired_d;
         dlast_q   <= dlast_d;
         gate_hi_q <= gate_hi_d;
         gate_lo_q <= gate_lo_d;
         for (int x = 0; x < 3; x++) dead_cnt_q[x] <= dead_cnt_d[x];
      end
   end

   assign GATE_HI = gate_hi_q;
   assign GATE_LO = gate_lo_q;

endmodule

// File: tb/tb_ac_motor_pwm_sequencer.sv
// Self-checking bench for ac_motor_pwm_sequencer: directed scenarios followed
// by randomized traffic, all compared against a timestamp-based model.
module tb_ac_motor_pwm_sequencer;

   localparam int OB   = 24;
   localparam int D    = 50;
   localparam int DB   = 8;
   localparam int CP   = 4;
   localparam int FF   = 4;
   localparam int HALF = 200;
   localparam int STP  = 100;
   localparam int AMP  = 10000;
   localparam longint NEVER = -1000000;

   logic                 CLK = 1'b0;
   logic                 RST_N;
   logic signed [OB-1:0] TRIANGLE;
   logic                 SYNC, START, STOP, FAULT, CLEAR;
   logic signed [OB-1:0] REF_A, REF_B, REF_C;
   logic                 REF_VALID;
   logic                 REF_READY;
   logic [2:0]           GATE_HI, GATE_LO;
   logic [1:0]           STATE;
   logic                 FAULT_LATCHED;

   always #5 CLK = ~CLK;

   ac_motor_pwm_sequencer #(
      .OUTPUT_BITS(OB), .DEAD_CYCLES(D), .DEAD_BITS(DB),
      .CHARGE_PERIODS(CP), .FAULT_FILTER(FF)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .TRIANGLE(TRIANGLE), .SYNC(SYNC),
      .START(START), .STOP(STOP), .FAULT(FAULT), .CLEAR(CLEAR),
      .REF_A(REF_A), .REF_B(REF_B), .REF_C(REF_C), .REF_VALID(REF_VALID),
      .REF_READY(REF_READY), .GATE_HI(GATE_HI), .GATE_LO(GATE_LO),
      .STATE(STATE), .FAULT_LATCHED(FAULT_LATCHED)
   );

   int     vectors = 0;
   int     miscompares = 0;
   longint n;        // index of the next rising edge
   int     tp;       // carrier phase, 0 .. 2*HALF-1
   int     tri_v;

   // Behavioural model state
   int     m_state, m_cc, m_fcnt;
   bit     m_stop, m_pend, m_xfer;
   longint m_active [3];
   longint m_shadow [3];
   bit [2:0] m_des, m_e, m_hi, m_lo;
   longint m_c [3];  // edge at which the phase's effective command last changed

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, n);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cc = 0; m_fcnt = 0; m_stop = 0; m_pend = 0; m_xfer = 0;
      m_des = 0; m_e = 0; m_hi = 0; m_lo = 0;
      for (int x = 0; x < 3; x++) begin
         m_active[x] = 0; m_shadow[x] = 0; m_c[x] = NEVER;
      end
   endtask

   // Advance the model across one rising edge using the inputs now applied.
   task automatic model_step();
      int     ns;
      bit     trip, rdy;
      bit [2:0] dn;
      bit     ev;
      longint refs [3];
`ifdef AC_MOTOR_SEQ_FAULT_FILTER_EN
      trip = FAULT && (m_fcnt >= FF - 1);
      m_fcnt = FAULT ? ((m_fcnt < 1000) ? m_fcnt + 1 : m_fcnt) : 0;
`else
      trip = FAULT;
`endif
      rdy = (m_state == 1 || m_state == 2) && !m_pend;
      ns = m_state;
      if (trip) ns = 3;
      else if (m_state == 0) begin
         if (START && !STOP && !FAULT) ns = 1;
      end else if (m_state == 1) begin
         if (STOP) ns = 0;
         else if (SYNC && (m_cc + 1 == CP)) ns = 2;
      end else if (m_state == 2) begin
         if (SYNC && (m_stop || STOP)) ns = 0;
      end else begin
         if (CLEAR && !FAULT) ns = 0;
      end
      m_cc   = (m_state == 1 && ns == 1) ? m_cc + int'(SYNC) : 0;
      m_stop = (m_state == 2 && ns == 2) ? (m_stop || STOP) : 1'b0;

      for (int x = 0; x < 3; x++) dn[x] = (m_active[x] > longint'(tri_v));

      // Gate outputs from the age of each phase's last command change.
      for (int x = 0; x < 3; x++) begin
         ev = (ns == 2) ? m_des[x] : 1'b0;
         if (ns != 2) m_c[x] = NEVER;
         else if (ev != m_e[x]) m_c[x] = n;
         m_e[x] = ev;
         m_hi[x] = 0; m_lo[x] = 0;
         if (ns == 1) m_lo[x] = 1;
         else if (ns == 2 && (n - m_c[x]) >= D) begin
            m_hi[x] = ev; m_lo[x] = !ev;
         end
      end

      refs[0] = longint'(REF_A); refs[1] = longint'(REF_B); refs[2] = longint'(REF_C);
      m_xfer = REF_VALID && rdy;
      if (m_xfer) for (int x = 0; x < 3; x++) m_shadow[x] = refs[x];
      if (!(ns == 1 || ns == 2)) m_pend = 0;
      else if (m_xfer) m_pend = 1;
      else if (SYNC && m_pend) begin
         for (int x = 0; x < 3; x++) m_active[x] = m_shadow[x];
         m_pend = 0;
      end
      m_des = dn;
      m_state = ns;
   endtask

   task automatic compare_all();
      chk("state", STATE, m_state);
      chk("gate_hi", GATE_HI, m_hi);
      chk("gate_lo", GATE_LO, m_lo);
      chk("ref_ready", REF_READY, (m_state == 1 || m_state == 2) && !m_pend);
      chk("fault_latched", FAULT_LATCHED, m_state == 3);
      chk("shoot_through", GATE_HI & GATE_LO, 0);
   endtask

   task automatic step();
      tri_v = (tp < HALF) ? (-AMP + STP * tp) : (AMP - STP * (tp - HALF));
      TRIANGLE = OB'(tri_v);
      SYNC = (tp == HALF);
      model_step();
      @(posedge CLK);
      #1;
      n++;
      compare_all();
      tp = (tp + 1) % (2 * HALF);
   endtask

   task automatic wait_tp(input int t);
      int k = 0;
      while (tp != t && k < 2 * HALF + 10) begin step(); k++; end
   endtask

   task automatic wait_state(input int s, input int budget, input string name);
      int k = 0;
      while (STATE != s && k < budget) begin step(); k++; end
      chk(name, STATE, s);
   endtask

   task automatic set_refs(input int a, input int b, input int c);
      REF_A = OB'(a); REF_B = OB'(b); REF_C = OB'(c);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int syncs, off, fall, rise, k, fb;
      longint icross;
      RST_N = 0; SYNC = 0; START = 0; STOP = 0; FAULT = 0; CLEAR = 0;
      REF_VALID = 0; set_refs(0, 0, 0); TRIANGLE = OB'(-AMP);
      model_reset(); n = 0; tp = 0; fb = 0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_state", STATE, 0);
      chk("rst_gates", {GATE_HI, GATE_LO}, 0);
      chk("rst_ready", REF_READY, 0);
      chk("rst_latched", FAULT_LATCHED, 0);
      RST_N = 1;
      repeat (5) step();

      // Start-up: CHARGE holds all low sides on for CP carrier peaks.
      START = 1; step(); START = 0;
      chk("start_state", STATE, 1);
      set_refs(20000, -20000, 0); REF_VALID = 1; step(); REF_VALID = 0;
      chk("charge_xfer_ready", REF_READY, 0);
      syncs = 0; k = 0;
      while (STATE == 1 && k < 3000) begin
         chk("charge_lo", GATE_LO, 3'b111);
         if (tp == HALF) syncs++;
         step(); k++;
      end
      chk("charge_syncs", syncs, CP);
      chk("run_state", STATE, 2);
      off = 0;
      while (GATE_HI[0] == 1'b0 && GATE_LO[0] == 1'b0 && off < 3 * D) begin
         off++; step();
      end
      chk("entry_dead", off, D);
      chk("entry_hi_a", GATE_HI[0], 1);

      // Mid-period transfer applies only at the next SYNC.
      wait_tp(100);
      set_refs(1000, -20000, 20000); REF_VALID = 1; step(); REF_VALID = 0;
      chk("mid_xfer_ready", REF_READY, 0);
      wait_tp(HALF); step();
      chk("sync_apply_ready", REF_READY, 1);

      // Rising carrier hits 1000 (equality counts as not-greater).
      wait_tp(110);
      icross = n;
      step();
      fall = -1; rise = -1; k = 0;
      while (rise < 0 && k < 3 * D) begin
         if (fall < 0 && GATE_HI[0] == 1'b0) fall = int'(n - icross);
         if (GATE_LO[0] == 1'b1) rise = int'(n - icross);
         else step();
         k++;
      end
      chk("turn_off_latency", fall, 2);
      chk("turn_on_latency", rise, D + 2);

      // Transfer on the SYNC cycle waits for the following SYNC.
      wait_tp(HALF);
      set_refs(500, -20000, 20000); REF_VALID = 1; step(); REF_VALID = 0;
      chk("syncx_ready", REF_READY, 0);
      wait_tp(HALF);
      chk("syncx_still_pending", REF_READY, 0);
      step();
      chk("syncx_applied", REF_READY, 1);

      // STOP mid-period with a pending shadow: run to the peak, then IDLE.
      wait_tp(300);
      set_refs(-20000, -20000, 20000); REF_VALID = 1; step(); REF_VALID = 0;
      wait_tp(320);
      STOP = 1; step();
      chk("stop_hold", STATE, 2);
      wait_tp(HALF);
      chk("stop_pre_sync", STATE, 2);
      step(); STOP = 0;
      chk("stop_idle", STATE, 0);
      chk("stop_gates", {GATE_HI, GATE_LO}, 0);

      // Restart: discarded shadow means phase A still runs with 500.
      START = 1; step(); START = 0;
      wait_state(2, 2500, "restart_run");
      wait_tp(360);
      chk("discard_hi_a", GATE_HI[0], 1);

      // Fault trip and clear.
`ifdef AC_MOTOR_SEQ_FAULT_FILTER_EN
      FAULT = 1; repeat (FF - 1) step(); FAULT = 0; step();
      chk("filter_short_pulse", STATE, 2);
      FAULT = 1; repeat (FF) step(); FAULT = 0;
      chk("filter_full_pulse", STATE, 3);
`else
      FAULT = 1; step(); FAULT = 0;
      chk("pulse_trip", STATE, 3);
`endif
      chk("fault_gates", {GATE_HI, GATE_LO}, 0);
      chk("fault_latched_hi", FAULT_LATCHED, 1);
      FAULT = 1; CLEAR = 1; step();
      chk("clear_ignored", STATE, 3);
      FAULT = 0; CLEAR = 0; step(); step();
      CLEAR = 1; step(); CLEAR = 0;
      chk("clear_idle", STATE, 0);
      chk("clear_latched_lo", FAULT_LATCHED, 0);

      // Asynchronous reset in the middle of RUN.
      START = 1; step(); START = 0;
      wait_state(2, 2500, "run_before_reset");
      repeat (2 * D) step();
      chk("pre_reset_active", |(GATE_HI | GATE_LO), 1);
      RST_N = 0;
      #2;
      chk("async_state", STATE, 0);
      chk("async_gates", {GATE_HI, GATE_LO}, 0);
      chk("async_ready", REF_READY, 0);
      @(posedge CLK); #1;
      chk("held_state", STATE, 0);
      chk("held_gates", {GATE_HI, GATE_LO}, 0);
      RST_N = 1;
      model_reset();

      // Randomized traffic.
      for (int i = 0; i < 20000; i++) begin
         START = (STATE == 2'd0) && ($urandom_range(0, 19) == 0);
         STOP  = ($urandom_range(0, 799) == 0);
         if (fb == 0 && $urandom_range(0, 2999) == 0) fb = $urandom_range(1, 6);
         FAULT = (fb > 0);
         if (fb > 0) fb--;
         CLEAR = (STATE == 2'd3) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
         if (!REF_VALID && $urandom_range(0, 29) == 0) begin
            set_refs(int'($urandom_range(0, 22000)) - 11000,
                     int'($urandom_range(0, 22000)) - 11000,
                     int'($urandom_range(0, 22000)) - 11000);
            REF_VALID = 1;
         end
         step();
         if (m_xfer) REF_VALID = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
